// File: rtl/lift_pkg.sv
// lift_pkg: shared state/direction encodings and parameter sanity check for the lift controller
package lift_pkg;
  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;
  function automatic bit params_ok(input int num_floors, input int travel_cyc, input int door_cyc);
    return num_floors >= 2 && travel_cyc >= 1 && door_cyc >= 1;
  endfunction
endpackage

// File: rtl/lift_dir_sel.sv
// lift_dir_sel: SCAN direction chooser; reports requests above/below/at floor and picks next direction
//   in  pending_i  request bitmap, floor_i current floor, last_dir_i previous travel direction
//   out above_o/below_o/here_o request presence, dir_o last_dir_i if requests lie that way, else reversed
module lift_dir_sel import lift_pkg::*; #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    floor_i,
  input  logic [1:0]            last_dir_i,
  output logic                  above_o,
  output logic                  below_o,
  output logic                  here_o,
  output logic [1:0]            dir_o
);
  always_comb begin
    above_o = 1'b0;
    below_o = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_o = above_o | (pending_i[i] && i > int'(floor_i));
      below_o = below_o | (pending_i[i] && i < int'(floor_i));
    end
  end

  assign here_o = pending_i[floor_i];
  assign dir_o = (last_dir_i == DIR_UP) ? (above_o ? DIR_UP : DIR_DN) : (below_o ? DIR_DN : DIR_UP);
endmodule

// File: rtl/lift_scan_ctrl.sv
// lift_scan_ctrl: multi-request SCAN elevator controller with travel time and door dwell
//   in  clk, rst_n (sync active-low), call_valid/call_floor hall calls, cab_valid/cab_floor cab buttons
//   out elev_f_o floor, busy_o not idle, dir_o 00/01/10, door_open_o, arrive_o stop pulse, pending_o requests
module lift_scan_ctrl import lift_pkg::*; #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic                  cab_valid,
  input  logic [FLOOR_W-1:0]    cab_floor,
  output logic [FLOOR_W-1:0]    elev_f_o,
  output logic                  busy_o,
  output logic [1:0]            dir_o,
  output logic                  door_open_o,
  output logic                  arrive_o,
  output logic [NUM_FLOORS-1:0] pending_o
);
  localparam int TW = TRAVEL_CYC > 1 ? $clog2(TRAVEL_CYC) : 1;
  localparam int DW = DOOR_CYC > 1 ? $clog2(DOOR_CYC) : 1;
  localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYC - 1);
  localparam logic [DW-1:0] DOOR_LD = DW'(DOOR_CYC - 1);

  if (!params_ok(NUM_FLOORS, TRAVEL_CYC, DOOR_CYC)) begin : g_bad_params
    $error("lift_scan_ctrl: NUM_FLOORS>=2, TRAVEL_CYC>=1, DOOR_CYC>=1 required");
  end

  state_t state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d, step_floor;
  logic [1:0] last_dir_q, last_dir_d, dir_q, dir_d, sel_dir;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, req_vec, nxt_pending, here_mask, step_mask;
  logic [TW-1:0] travel_cnt_q, travel_cnt_d;
  logic [DW-1:0] door_cnt_q, door_cnt_d;
  logic arrive_q, arrive_d, busy_q, busy_d, door_q, door_d;
  logic above, below, here;

  // Out-of-range indices match no bit, so they drop out here.
  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      req_vec[i] = (call_valid && int'(call_floor) == i) || (cab_valid && int'(cab_floor) == i);
  end

  assign here_mask = NUM_FLOORS'(1) << floor_q;
  assign step_floor = (last_dir_q == DIR_UP) ? floor_q + 1'b1 : floor_q - 1'b1;
  assign step_mask = NUM_FLOORS'(1) << step_floor;
  // With the door open, a request for this floor is served by the open door and never latched.
  assign nxt_pending = (pending_q | req_vec) & ~((state_q == DOOR) ? here_mask : '0);

  lift_dir_sel #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_dir_sel (
    .pending_i (nxt_pending),
    .floor_i   (floor_q),
    .last_dir_i(last_dir_q),
    .above_o   (above),
    .below_o   (below),
    .here_o    (here),
    .dir_o     (sel_dir)
  );

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    last_dir_d = last_dir_q;
    travel_cnt_d = travel_cnt_q;
    door_cnt_d = door_cnt_q;
    pending_d = nxt_pending;
    arrive_d = 1'b0;
    case (state_q)
      IDLE:
        if (here) begin
          state_d = DOOR;
          pending_d = nxt_pending & ~here_mask;
          arrive_d = 1'b1;
          door_cnt_d = DOOR_LD;
        end else if (above || below) begin
          state_d = MOVE;
          last_dir_d = sel_dir;
          travel_cnt_d = TRAVEL_LD;
        end
      MOVE:
        if (travel_cnt_q != '0) travel_cnt_d = travel_cnt_q - 1'b1;
        else begin
          floor_d = step_floor;
          if (nxt_pending[step_floor]) begin
            state_d = DOOR;
            pending_d = nxt_pending & ~step_mask;
            arrive_d = 1'b1;
            door_cnt_d = DOOR_LD;
          end else travel_cnt_d = TRAVEL_LD;
        end
      DOOR:
        if (req_vec[floor_q]) door_cnt_d = DOOR_LD;
        else if (door_cnt_q != '0) door_cnt_d = door_cnt_q - 1'b1;
        else if (above || below) begin
          state_d = MOVE;
          last_dir_d = sel_dir;
          travel_cnt_d = TRAVEL_LD;
        end else state_d = IDLE;
      default: state_d = IDLE;
    endcase
    dir_d = (state_d == MOVE) ? last_dir_d : DIR_IDLE;
    busy_d = state_d != IDLE;
    door_d = state_d == DOOR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      floor_q <= '0;
      last_dir_q <= DIR_UP;
      dir_q <= DIR_IDLE;
      pending_q <= '0;
      travel_cnt_q <= '0;
      door_cnt_q <= '0;
      arrive_q <= 1'b0;
      busy_q <= 1'b0;
      door_q <= 1'b0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      last_dir_q <= last_dir_d;
      dir_q <= dir_d;
      pending_q <= pending_d;
      travel_cnt_q <= travel_cnt_d;
      door_cnt_q <= door_cnt_d;
      arrive_q <= arrive_d;
      busy_q <= busy_d;
      door_q <= door_d;
    end
  end

  // Travel only ever heads toward a pending bit, so a step can never leave the shaft.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == MOVE && travel_cnt_q == '0)
      assert (last_dir_q == DIR_UP ? int'(floor_q) < NUM_FLOORS - 1 : floor_q != '0)
        else $error("lift_scan_ctrl: step beyond shaft end");
  end

  assign elev_f_o = floor_q;
  assign busy_o = busy_q;
  assign dir_o = dir_q;
  assign door_open_o = door_q;
  assign arrive_o = arrive_q;
  assign pending_o = pending_q;
endmodule

// File: tb/tb_lift_scan_ctrl.sv
// tb_lift_scan_ctrl: directed self-checking bench for lift_scan_ctrl (8-floor and 5-floor instances)
module tb_lift_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic call_valid = 1'b0, cab_valid = 1'b0, c5_valid = 1'b0, c5_cab_valid = 1'b0;
  logic [2:0] call_floor = '0, cab_floor = '0, c5_floor = '0, c5_cab_floor = '0;
  logic [2:0] elev_f_o, elev5;
  logic busy_o, busy5, door_open_o, door5, arrive_o, arrive5;
  logic [1:0] dir_o, dir5;
  logic [7:0] pending_o;
  logic [4:0] pending5;
  int checks = 0;
  int failures = 0;
  int n, cyc;
  int stop_f[4];
  int stop_d[4];
  logic [1:0] prev;

  always #5 clk = ~clk;

  lift_scan_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .call_valid(call_valid), .call_floor(call_floor),
    .cab_valid(cab_valid), .cab_floor(cab_floor),
    .elev_f_o(elev_f_o), .busy_o(busy_o), .dir_o(dir_o),
    .door_open_o(door_open_o), .arrive_o(arrive_o), .pending_o(pending_o)
  );

  lift_scan_ctrl #(.NUM_FLOORS(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .call_valid(c5_valid), .call_floor(c5_floor),
    .cab_valid(c5_cab_valid), .cab_floor(c5_cab_floor),
    .elev_f_o(elev5), .busy_o(busy5), .dir_o(dir5),
    .door_open_o(door5), .arrive_o(arrive5), .pending_o(pending5)
  );

  task automatic ticks(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic cv, input logic [2:0] cf, input logic bv, input logic [2:0] bf);
    call_valid = cv;
    call_floor = cf;
    cab_valid = bv;
    cab_floor = bf;
    ticks(1);
    call_valid = 1'b0;
    cab_valid = 1'b0;
  endtask

  initial begin
    ticks(2);
    chk("rst_floor", elev_f_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_dir", dir_o, 0);
    chk("rst_door", door_open_o, 0);
    chk("rst_pend", pending_o, 8'h00);
    chk("rst_arrive", arrive_o, 0);
    rst_n = 1'b1;
    ticks(1);
    c5_valid = 1'b1;
    c5_floor = 3'd7;
    ticks(1);
    c5_valid = 1'b0;
    chk("nf5_drop_pend", pending5, 5'h00);
    chk("nf5_drop_busy", busy5, 0);
    ticks(1);
    chk("nf5_drop_busy2", busy5, 0);
    c5_valid = 1'b1;
    c5_floor = 3'd4;
    ticks(1);
    c5_valid = 1'b0;
    chk("nf5_top_pend", pending5, 5'h10);
    chk("nf5_top_busy", busy5, 1);
    press(1'b1, 3'd3, 1'b0, 3'd0);
    chk("single_pend", pending_o, 8'h08);
    chk("single_busy", busy_o, 1);
    chk("single_dir", dir_o, 2'b01);
    chk("single_e1_floor", elev_f_o, 0);
    ticks(3);
    chk("single_e4_floor", elev_f_o, 0);
    ticks(1);
    chk("single_e5_floor", elev_f_o, 1);
    ticks(4);
    chk("single_e9_floor", elev_f_o, 2);
    ticks(3);
    chk("single_e12_arrive", arrive_o, 0);
    ticks(1);
    chk("single_e13_floor", elev_f_o, 3);
    chk("single_e13_arrive", arrive_o, 1);
    chk("single_e13_door", door_open_o, 1);
    chk("single_e13_pend", pending_o, 8'h00);
    ticks(5);
    chk("single_e18_door", door_open_o, 1);
    chk("single_e18_arrive", arrive_o, 0);
    ticks(1);
    chk("single_e19_door", door_open_o, 0);
    chk("single_e19_busy", busy_o, 0);
    chk("single_e19_dir", dir_o, 0);
    press(1'b0, 3'd0, 1'b1, 3'd3);
    chk("dext_arrive", arrive_o, 1);
    chk("dext_door", door_open_o, 1);
    ticks(3);
    press(1'b0, 3'd0, 1'b1, 3'd3);
    chk("dext_pend", pending_o, 8'h00);
    chk("dext_no_rearrive", arrive_o, 0);
    chk("dext_door_d4", door_open_o, 1);
    ticks(2);
    chk("dext_door_d6", door_open_o, 1);
    ticks(3);
    chk("dext_door_d9", door_open_o, 1);
    chk("dext_arrive_d9", arrive_o, 0);
    ticks(1);
    chk("dext_door_d10", door_open_o, 0);
    chk("dext_busy_d10", busy_o, 0);
    press(1'b1, 3'd0, 1'b0, 3'd0);
    chk("mvrst_dir", dir_o, 2'b10);
    ticks(4);
    chk("mvrst_floor_pre", elev_f_o, 2);
    rst_n = 1'b0;
    ticks(1);
    chk("mvrst_floor", elev_f_o, 0);
    chk("mvrst_busy", busy_o, 0);
    chk("mvrst_pend", pending_o, 8'h00);
    chk("mvrst_dir0", dir_o, 0);
    rst_n = 1'b1;
    ticks(1);
    press(1'b1, 3'd3, 1'b1, 3'd3);
    chk("merge_pend", pending_o, 8'h08);
    chk("merge_busy", busy_o, 1);
    rst_n = 1'b0;
    ticks(1);
    rst_n = 1'b1;
    ticks(1);
    press(1'b1, 3'd5, 1'b0, 3'd0);
    ticks(4);
    chk("scan_at1", elev_f_o, 1);
    press(1'b1, 3'd0, 1'b1, 3'd2);
    chk("scan_pend", pending_o, 8'h25);
    n = 0;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      stop_f[i] = -1;
      stop_d[i] = -1;
    end
    while (busy_o && cyc < 300) begin
      prev = dir_o;
      ticks(1);
      cyc++;
      if (arrive_o && n < 4) begin
        stop_f[n] = int'(elev_f_o);
        stop_d[n] = int'(prev);
        n++;
      end
    end
    chk("scan_idle", busy_o, 0);
    chk("scan_nstops", n, 3);
    chk("scan_stop0", stop_f[0], 2);
    chk("scan_dir0", stop_d[0], 1);
    chk("scan_stop1", stop_f[1], 5);
    chk("scan_dir1", stop_d[1], 1);
    chk("scan_stop2", stop_f[2], 0);
    chk("scan_dir2", stop_d[2], 2);
    chk("scan_pend_end", pending_o, 8'h00);
    press(1'b1, 3'd4, 1'b0, 3'd0);
    ticks(7);
    chk("arrcyc_floor_pre", elev_f_o, 1);
    chk("arrcyc_arrive_pre", arrive_o, 0);
    press(1'b0, 3'd0, 1'b1, 3'd2);
    chk("arrcyc_floor", elev_f_o, 2);
    chk("arrcyc_arrive", arrive_o, 1);
    chk("arrcyc_door", door_open_o, 1);
    chk("arrcyc_pend", pending_o, 8'h10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lift_scan_ctrl.md
Name: lift_scan_ctrl

Overview:
Parametrised elevator controller, successor to the fixed 8-floor single-request lift. It latches hall calls and cab requests for any number of floors into a pending bitmap and serves them in SCAN order: continue in the current direction while requests lie ahead, then reverse. It models per-floor travel time and a door-open dwell. It sits between the floor/cab button decoders and the floor display and motor/door drivers.

Parameters:
NUM_FLOORS, 8, number of floors (>=2); floors are numbered 0..NUM_FLOORS-1.
FLOOR_W, $clog2(NUM_FLOORS), width of floor indices.
TRAVEL_CYC, 4, clock cycles to travel one floor (>=1).
DOOR_CYC, 6, clock cycles the door stays open per stop (>=1).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  synchronous, active-low reset.
call_valid  in  1  hall-call strobe, one cycle per press.
call_floor  in  FLOOR_W  floor of the hall call.
cab_valid  in  1  cab-button strobe.
cab_floor  in  FLOOR_W  destination floor pressed in the cab.
elev_f_o  out  FLOOR_W  current floor.
busy_o  out  1  1 when state != IDLE.
dir_o  out  2  00 idle, 01 up, 10 down.
door_open_o  out  1  1 while in DOOR.
arrive_o  out  1  one-cycle pulse on the cycle a stop begins.
pending_o  out  NUM_FLOORS  outstanding request bitmap.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, elev_f_o=0, dir_o=00, last_dir=UP, door_open_o=0, arrive_o=0, pending_o=0, counters=0. This applies from any state, mid-travel included.
- Request intake: req_vec = onehot(call_floor) if call_valid, OR onehot(cab_floor) if cab_valid. Indices >= NUM_FLOORS are dropped silently. Call and cab for the same floor in the same cycle merge into one bit.
- nxt_pending = pending | req_vec, then minus any bit cleared by a stop this cycle. A request is visible on pending_o one edge after its strobe.
- above = any nxt_pending bit > floor; below = any nxt_pending bit < floor; here = nxt_pending[floor].
- IDLE:
  - If here, go to DOOR, clear the bit, pulse arrive_o.
  - Else if above or below, go to MOVE. Direction is last_dir if requests lie that way, otherwise the opposite. Load travel_cnt = TRAVEL_CYC-1.
  - Else stay in IDLE with dir_o=00.
- MOVE:
  - dir_o reflects the direction of travel; travel_cnt decrements each cycle.
  - On the cycle travel_cnt==0, floor moves ±1.
  - If nxt_pending[new floor] (a request arriving that same cycle counts), go to DOOR, clear the bit, pulse arrive_o, load door_cnt = DOOR_CYC-1.
  - Otherwise reload travel_cnt and continue.
  - The first floor change happens TRAVEL_CYC edges after MOVE is entered.
- DOOR:
  - door_open_o=1; door_cnt decrements each cycle.
  - A request for the current floor while in DOOR is not latched; it reloads door_cnt = DOOR_CYC-1.
  - When door_cnt==0:
    - if requests lie ahead in last_dir, go to MOVE in the same direction;
    - else if requests lie behind, go to MOVE reversed (last_dir flips);
    - else go to IDLE.
- The controller never moves past floor 0 or NUM_FLOORS-1, because it only moves toward a pending bit. An assertion checks this.
- busy_o = (state != IDLE). All outputs are registered.

Decomposition:
- Package lift_pkg holds:
  - state enum {IDLE, MOVE, DOOR};
  - dir encoding constants DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DN=2'b10;
  - an elaboration-time parameter check (NUM_FLOORS>=2, TRAVEL_CYC>=1, DOOR_CYC>=1).
- One sub-module, lift_dir_sel: combinational. Takes pending, floor and last_dir. Returns above, below, here and the chosen next direction. It is reusable by a future multi-car dispatcher.

Test Plan:
(All with defaults NUM_FLOORS=8, TRAVEL_CYC=4, DOOR_CYC=6.)
1. Reset: hold rst_n=0 for 2 edges -> elev_f_o=0, busy_o=0, dir_o=00, door_open_o=0, pending_o=8'h00. Repeat with rst_n low while in MOVE at floor 2 -> next edge elev_f_o=0, IDLE, pending_o=0.
2. Single call: call_floor=3 at edge E0 from floor 0.
   - pending_o=8'h08 at E1; MOVE up from E1.
   - elev_f_o=1/2/3 at E5/E9/E13; arrive_o pulse at E13.
   - door_open_o high for 6 cycles; then IDLE, busy_o=0, pending_o=0.
3. SCAN ordering: from floor 0, call 5. Just after reaching floor 1, issue cab 2 and call 0 -> stops in order 2, 5, then reverses (dir_o=10) and stops at 0. There is no stop at 0 on the way up.
4. Door extend: while in DOOR at floor 3, cab_floor=3 at the 4th open cycle -> door stays open 6 more cycles from that point; pending_o stays 0; no second arrive_o.
5. Invalid/merged input: call_floor=3 and cab_floor=3 in the same cycle -> pending_o=8'h08 (single stop). Rerun with NUM_FLOORS=5 and call_floor=7 -> pending_o=0, busy_o stays 0.
6. Arrival-cycle request: while moving up from 1 to 2, cab_floor=2 on the exact cycle travel_cnt==0 -> elevator stops at 2 that edge and arrive_o pulses.
